// File: rtl/vector_ram_pkg.sv
// vector_ram_pkg: state type, default widths and the lane-address
// helper shared by the vector RAM initiator and its address generator.
package vector_ram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } initiator_state_t;

  localparam int VR_VECTOR_LENGTH   = 32;
  localparam int VR_DATA_WIDTH      = 32;
  localparam int VR_PARALLELISM     = 4;
  localparam int VR_MAX_OUTSTANDING = 4;

  // Unwrapped element index; callers truncate to their address width,
  // which gives the modulo-VECTOR_LENGTH wrap for free.
  function automatic logic [31:0] lane_addr(
    input logic [31:0] base,
    input logic [31:0] beat,
    input logic [31:0] par,
    input logic [31:0] lane
  );
    return base + beat * par + lane;
  endfunction

endpackage

// File: rtl/vector_ram_addr_gen.sv
// vector_ram_addr_gen: latches the base on load, counts beats on step.
// Ports: clk, rst, load, step, base in; beat count, lane addresses out.
module vector_ram_addr_gen
  import vector_ram_pkg::*;
#(
  parameter int VECTOR_LENGTH = VR_VECTOR_LENGTH,
  parameter int PARALLELISM   = VR_PARALLELISM,
  parameter int ADDR_WIDTH    = $clog2(VECTOR_LENGTH),
  parameter int BEAT_WIDTH    = $clog2(VECTOR_LENGTH/PARALLELISM+1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load,
  input  logic                            step,
  input  logic [ADDR_WIDTH-1:0]           base,
  output logic [BEAT_WIDTH-1:0]           beat,
  output logic [PARALLELISM*ADDR_WIDTH-1:0] addr
);

  logic [ADDR_WIDTH-1:0] base_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q <= '0;
      beat   <= '0;
    end else if (load) begin
      base_q <= base;
      beat   <= '0;
    end else if (step) begin
      beat   <= beat + BEAT_WIDTH'(1);
    end
  end

  for (genvar i = 0; i < PARALLELISM; i++) begin : g_lane
    assign addr[i*ADDR_WIDTH +: ADDR_WIDTH] =
      ADDR_WIDTH'(lane_addr(32'(base_q), 32'(beat),
                            32'(PARALLELISM), 32'(i)));
  end

endmodule

// File: rtl/vector_ram_initiator.sv
// vector_ram_initiator: walks one read/write vector command over vector_ram.
// Ports: cmd_* in, ram_* req/resp, in_* write stream, out_* read stream,
// busy/done status; perf_stall_cycles with VECTOR_RAM_INITIATOR_PERF_EN.
module vector_ram_initiator
  import vector_ram_pkg::*;
#(
  parameter int VECTOR_LENGTH   = VR_VECTOR_LENGTH,
  parameter int DATA_WIDTH      = VR_DATA_WIDTH,
  parameter int PARALLELISM     = VR_PARALLELISM,
  parameter int MAX_OUTSTANDING = VR_MAX_OUTSTANDING,
  localparam int ADDR_WIDTH = $clog2(VECTOR_LENGTH),
  localparam int BEAT_WIDTH = $clog2(VECTOR_LENGTH/PARALLELISM+1),
  localparam int CNT_WIDTH  = $clog2(MAX_OUTSTANDING+1),
  localparam int VW = PARALLELISM*DATA_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [ADDR_WIDTH-1:0]           cmd_base,
  input  logic [BEAT_WIDTH-1:0]           cmd_beats,
  output logic [PARALLELISM*ADDR_WIDTH-1:0] ram_addr,
  output logic [VW-1:0]                   ram_wdata,
  output logic                            ram_write,
  output logic                            ram_valid,
  input  logic                            ram_ready,
  input  logic [VW-1:0]                   ram_rdata,
  input  logic                            ram_rvalid,
  output logic                            ram_rready,
  input  logic [VW-1:0]                   in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [VW-1:0]                   out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last,
  output logic                            busy,
`ifdef VECTOR_RAM_INITIATOR_PERF_EN
  output logic [31:0]                     perf_stall_cycles,
`endif
  output logic                            done
);

  initiator_state_t state, nstate;

  logic                  write_q;
  logic [BEAT_WIDTH-1:0] beats_q;
  logic [BEAT_WIDTH-1:0] beat;
  logic [BEAT_WIDTH-1:0] resp_cnt;
  logic [CNT_WIDTH-1:0]  outst;

  logic cmd_fire;
  logic req_fire;
  logic rd_act;
  logic rsp_fire;
  logic last_beat;
  logic rsp_done;
  logic inc;
  logic dec;

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign req_fire  = ram_valid && ram_ready;
  assign rd_act    = !write_q && (state == ISSUE || state == DRAIN);
  assign rsp_fire  = rd_act && ram_rvalid && out_ready;
  assign last_beat = beat == beats_q - BEAT_WIDTH'(1);
  // Look ahead one response so done lands the cycle after the last one.
  assign rsp_done  =
    (resp_cnt + BEAT_WIDTH'(rsp_fire)) == beats_q;

  assign inc = req_fire && !write_q;
  // A protocol-violating extra response must not wrap the counter.
  assign dec = rsp_fire && (outst != '0);

  vector_ram_addr_gen #(
    .VECTOR_LENGTH (VECTOR_LENGTH),
    .PARALLELISM   (PARALLELISM),
    .ADDR_WIDTH    (ADDR_WIDTH),
    .BEAT_WIDTH    (BEAT_WIDTH)
  ) u_addr_gen (
    .clk  (clk),
    .rst  (rst),
    .load (cmd_fire),
    .step (req_fire),
    .base (cmd_base),
    .beat (beat),
    .addr (ram_addr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:
        if (cmd_fire)
          nstate = (cmd_beats == '0) ? DONE : ISSUE;
      ISSUE:
        if (req_fire && last_beat)
          nstate = write_q ? DONE : DRAIN;
      DRAIN:
        if (rsp_done) nstate = DONE;
      DONE:
        nstate = IDLE;
      default:
        nstate = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    ram_valid = 1'b0;
    in_ready  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      ISSUE:
        if (write_q) begin
          ram_valid = in_valid;
          in_ready  = ram_ready;
        end else begin
          ram_valid =
            outst < CNT_WIDTH'(MAX_OUTSTANDING);
        end
      DONE:
        done = 1'b1;
      default: ;
    endcase
  end

  assign ram_write  = write_q;
  assign ram_wdata  = in_data;
  assign out_data   = ram_rdata;
  assign out_valid  = rd_act && ram_rvalid;
  assign ram_rready = rd_act ? out_ready : 1'b1;
  assign out_last   = out_valid &&
    (resp_cnt == beats_q - BEAT_WIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q  <= 1'b0;
      beats_q  <= '0;
      resp_cnt <= '0;
      outst    <= '0;
    end else if (cmd_fire) begin
      write_q  <= cmd_write;
      beats_q  <= cmd_beats;
      resp_cnt <= '0;
      outst    <= '0;
    end else begin
      if (rsp_fire)
        resp_cnt <= resp_cnt + BEAT_WIDTH'(1);
      if (inc && !dec)
        outst <= outst + CNT_WIDTH'(1);
      else if (dec && !inc)
        outst <= outst - CNT_WIDTH'(1);
    end
  end

`ifdef VECTOR_RAM_INITIATOR_PERF_EN
  logic [31:0] stall_q;
  logic        stall;

  assign stall = (ram_valid && !ram_ready) ||
                 (out_valid && !out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_q <= '0;
    else if (cmd_fire)
      stall_q <= '0;
    else if (stall && stall_q != '1)
      stall_q <= stall_q + 32'd1;
  end

  assign perf_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_vector_ram_initiator.sv
// tb_vector_ram_initiator: scoreboard bench with a RAM model, a write-data
// source and a reference model of the expected request/response streams.
module tb_vector_ram_initiator;

  localparam int VL = 32;
  localparam int DW = 32;
  localparam int P  = 4;
  localparam int MO = 4;
  localparam int AW = $clog2(VL);
  localparam int BW = $clog2(VL/P+1);
  localparam int VW = P*DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_write = 1'b0;
  logic [AW-1:0] cmd_base = '0;
  logic [BW-1:0] cmd_beats = '0;
  logic cmd_ready;
  logic [P*AW-1:0] ram_addr;
  logic [VW-1:0] ram_wdata;
  logic [VW-1:0] ram_rdata;
  logic [VW-1:0] in_data;
  logic [VW-1:0] out_data;
  logic ram_write, ram_valid, ram_ready;
  logic ram_rvalid, ram_rready;
  logic in_valid, in_ready;
  logic out_valid, out_ready, out_last;
  logic busy, done;
`ifdef VECTOR_RAM_INITIATOR_PERF_EN
  logic [31:0] perf_stall_cycles;
`endif

  vector_ram_initiator #(
    .VECTOR_LENGTH   (VL),
    .DATA_WIDTH      (DW),
    .PARALLELISM     (P),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_base   (cmd_base),
    .cmd_beats  (cmd_beats),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_write  (ram_write),
    .ram_valid  (ram_valid),
    .ram_ready  (ram_ready),
    .ram_rdata  (ram_rdata),
    .ram_rvalid (ram_rvalid),
    .ram_rready (ram_rready),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
`ifdef VECTOR_RAM_INITIATOR_PERF_EN
    .perf_stall_cycles (perf_stall_cycles),
`endif
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [P*AW-1:0] addr;
    logic            wr;
    logic [VW-1:0]   wdata;
    logic            fin;
  } req_t;

  typedef struct {
    logic [VW-1:0] data;
    logic          last;
  } out_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_exp = 0;
  int last_evt = 0;
  int outst_m = 0;
  int rd_issued = 0;
  int rdy_pct = 100;
  int rv_pct = 100;
  int iv_pct = 100;
  int or_pct = 100;
  bit iv_toggle = 1'b0;

  logic [DW-1:0] ref_mem [VL];
  logic [DW-1:0] ram_mem [VL];
  req_t          exp_req_q [$];
  out_t          exp_out_q [$];
  logic [VW-1:0] wsrc_q [$];
  logic [VW-1:0] resp_q [$];

  task automatic chk(input string nm, input logic [VW-1:0] act,
                     input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] rvec();
    logic [VW-1:0] v;
    for (int i = 0; i < P; i++) v[i*DW +: DW] = DW'($urandom());
    return v;
  endfunction

  // RAM model: accepts requests, queues read data, returns it in order.
  initial begin
    logic [VW-1:0] d;
    ram_ready  = 1'b0;
    ram_rvalid = 1'b0;
    ram_rdata  = '0;
    forever begin
      @(negedge clk);
      if (ram_valid && ram_ready) begin
        d = '0;
        for (int i = 0; i < P; i++) begin
          if (ram_write)
            ram_mem[ram_addr[i*AW +: AW]] = ram_wdata[i*DW +: DW];
          else
            d[i*DW +: DW] = ram_mem[ram_addr[i*AW +: AW]];
        end
        if (!ram_write) resp_q.push_back(d);
      end
      if (ram_rvalid && ram_rready && resp_q.size() > 0)
        void'(resp_q.pop_front());
      @(posedge clk);
      #1;
      ram_ready  = ($urandom_range(99) < rdy_pct);
      ram_rvalid = (resp_q.size() > 0) && ($urandom_range(99) < rv_pct);
      ram_rdata  = (resp_q.size() > 0) ? resp_q[0] : rvec();
    end
  end

  // Write-data source.
  initial begin
    bit tog;
    tog      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    forever begin
      @(negedge clk);
      if (in_valid && in_ready && wsrc_q.size() > 0)
        void'(wsrc_q.pop_front());
      @(posedge clk);
      #1;
      tog = !tog;
      in_valid = (wsrc_q.size() > 0) &&
        (iv_toggle ? tog : ($urandom_range(99) < iv_pct));
      in_data = in_valid ? wsrc_q[0] : rvec();
    end
  end

  // Read-data sink back-pressure.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = ($urandom_range(99) < or_pct);
    end
  end

  // Monitor: compares every handshake against the scoreboard queues.
  initial begin
    req_t r;
    out_t o;
    forever begin
      @(negedge clk);
      cyc++;
      if (cmd_valid && cmd_ready) begin
        last_evt = cyc;
        done_exp++;
      end
      if (ram_valid && ram_ready) begin
        if (exp_req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL req_unexpected: addr %0h write %b, required none",
                   ram_addr, ram_write);
        end else begin
          r = exp_req_q.pop_front();
          chk("req_addr", VW'(ram_addr), VW'(r.addr));
          chkb("req_write", ram_write, r.wr);
          if (r.wr) begin
            chk("req_wdata", ram_wdata, r.wdata);
          end else begin
            chkb("outstanding_cap", outst_m < MO, 1'b1);
            outst_m++;
            rd_issued++;
          end
          if (r.fin) last_evt = cyc;
        end
      end
      if (out_valid && out_ready) begin
        if (exp_out_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected: data %0h, required no beat",
                   out_data);
        end else begin
          o = exp_out_q.pop_front();
          chk("out_data", out_data, o.data);
          chkb("out_last", out_last, o.last);
          if (outst_m > 0) outst_m--;
          if (o.last) last_evt = cyc;
        end
      end
      if (done) begin
        if (done_exp == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected: done=1 required 0 at cycle %0d",
                   cyc);
        end else begin
          done_exp--;
          chki("done_latency", cyc, last_evt + 1);
        end
      end
    end
  end

  task automatic apply_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    exp_req_q.delete();
    exp_out_q.delete();
    wsrc_q.delete();
    resp_q.delete();
    done_exp = 0;
    outst_m  = 0;
    @(negedge clk);
    chkb("rst_cmd_ready", cmd_ready, 1'b1);
    chkb("rst_ram_valid", ram_valid, 1'b0);
    chkb("rst_out_valid", out_valid, 1'b0);
    chkb("rst_in_ready", in_ready, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_done", done, 1'b0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // Reference model: element (base + b*P + i) mod VL per lane, in order.
  task automatic start_cmd(input bit wr, input int base, input int beats);
    req_t r;
    out_t o;
    int a;
    int n;
    for (int b = 0; b < beats; b++) begin
      r.addr  = '0;
      r.wdata = '0;
      o.data  = '0;
      r.wr    = wr;
      r.fin   = wr && (b == beats - 1);
      o.last  = (b == beats - 1);
      for (int i = 0; i < P; i++) begin
        a = (base + b*P + i) % VL;
        r.addr[i*AW +: AW] = AW'(a);
        if (wr) begin
          r.wdata[i*DW +: DW] = DW'($urandom());
          ref_mem[a] = r.wdata[i*DW +: DW];
        end else begin
          o.data[i*DW +: DW] = ref_mem[a];
        end
      end
      exp_req_q.push_back(r);
      if (wr) wsrc_q.push_back(r.wdata);
      else    exp_out_q.push_back(o);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_base  = AW'(base);
    cmd_beats = BW'(beats);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 50);
    chkb("cmd_accept", cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom_range(1));
    cmd_base  = AW'($urandom());
    cmd_beats = BW'($urandom_range(8));
  endtask

  task automatic wait_done(input int lim);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < lim);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", lim);
      apply_reset();
    end else begin
      @(negedge clk);
      chkb("busy_after_done", busy, 1'b0);
      chki("scoreboard_empty",
           exp_req_q.size() + exp_out_q.size(), 0);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s;
    for (int i = 0; i < VL; i++) begin
      ref_mem[i] = DW'($urandom());
      ram_mem[i] = ref_mem[i];
    end
    apply_reset();

    // Full read from 0, first request the cycle after accept.
    start_cmd(1'b0, 0, 8);
    @(negedge clk);
    chkb("first_req_latency", ram_valid, 1'b1);
    wait_done(500);

    // Wrap-around read.
    start_cmd(1'b0, 28, 2);
    wait_done(500);

    // Outstanding limit under sink back-pressure.
    or_pct = 0;
    s = rd_issued;
    start_cmd(1'b0, 0, 8);
    repeat (12) @(negedge clk);
    chki("stall_issued", rd_issued - s, MO);
    chkb("stall_ram_valid", ram_valid, 1'b0);
    or_pct = 100;
    wait_done(500);

    // Write with toggling in_valid, then read the data back.
    iv_toggle = 1'b1;
    start_cmd(1'b1, 5, 3);
    wait_done(500);
    iv_toggle = 1'b0;
    start_cmd(1'b0, 5, 3);
    wait_done(500);

    // Zero-beat command.
    start_cmd(1'b0, 7, 0);
    @(negedge clk);
    chkb("zero_no_req", ram_valid, 1'b0);
    chkb("zero_done", done, 1'b1);
    @(negedge clk);
    chkb("zero_busy_after", busy, 1'b0);

    // Reset while draining, then a fresh command.
    or_pct = 0;
    start_cmd(1'b0, 4, 2);
    repeat (4) @(negedge clk);
    chkb("drain_busy", busy, 1'b1);
    chkb("drain_no_req", ram_valid, 1'b0);
    apply_reset();
    or_pct = 100;
    start_cmd(1'b0, 4, 2);
    wait_done(500);

    // Randomized commands and handshake pressure.
    for (int k = 0; k < 40; k++) begin
      rdy_pct = $urandom_range(100, 30);
      rv_pct  = $urandom_range(100, 30);
      iv_pct  = $urandom_range(100, 30);
      or_pct  = $urandom_range(100, 30);
      start_cmd(1'($urandom_range(1)), $urandom_range(VL - 1),
                $urandom_range(VL / P));
      wait_done(3000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
